// File: rtl/multi_cycle_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit.
// Opcode patterns are value/mask pairs so the decoder can match don't-care bits.
package multi_cycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_CBZ   = 3'd3,
    CLS_B     = 3'd4
  } op_class_e;

  localparam logic [10:0] MASK_EXACT = 11'b111_1111_1111;

  localparam logic [10:0] OP_LDUR_VAL    = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR_VAL    = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADDREG_VAL  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUBREG_VAL  = 11'b110_0101_1000;
  localparam logic [10:0] OP_ANDREG_VAL  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORRREG_VAL  = 11'b101_0101_0000;
  localparam logic [10:0] OP_ADDIMM_VAL  = 11'b100_1000_1000;
  localparam logic [10:0] OP_ADDIMM_MASK = 11'b111_1111_1110;
  localparam logic [10:0] OP_SUBIMM_VAL  = 11'b110_1000_1000;
  localparam logic [10:0] OP_SUBIMM_MASK = 11'b111_1111_1110;
  localparam logic [10:0] OP_CBZ_VAL     = 11'b101_1010_0000;
  localparam logic [10:0] OP_CBZ_MASK    = 11'b111_1111_1000;
  localparam logic [10:0] OP_B_VAL       = 11'b000_1010_0000;
  localparam logic [10:0] OP_B_MASK      = 11'b111_1110_0000;
  localparam logic [10:0] OP_MOVZ_VAL    = 11'b110_1001_0100;
  localparam logic [10:0] OP_MOVZ_MASK   = 11'b111_1111_1100;

  localparam logic [3:0] ALUOP_AND   = 4'b0000;
  localparam logic [3:0] ALUOP_ORR   = 4'b0001;
  localparam logic [3:0] ALUOP_ADD   = 4'b0010;
  localparam logic [3:0] ALUOP_SUB   = 4'b0110;
  localparam logic [3:0] ALUOP_PASSB = 4'b0111;

  localparam logic [2:0] SIGNOP_ARITH = 3'b000;
  localparam logic [2:0] SIGNOP_DT    = 3'b001;
  localparam logic [2:0] SIGNOP_BR    = 3'b010;
  localparam logic [2:0] SIGNOP_CB    = 3'b011;
  localparam logic [2:0] SIGNOP_MOV   = 3'b100;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/multi_cycle_control_decode.sv
// Combinational LEGv8 opcode decoder: legality, instruction class and datapath selects.
// Selects an instruction does not use are left at 0.
module legv8_decode
  import multi_cycle_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 4,
  parameter int SIGNOP_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                legal,
  output op_class_e           op_class,
  output logic                reg2loc,
  output logic                alusrc,
  output logic                mem2reg,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [SIGNOP_W-1:0] signop
);

  always_comb begin
    legal    = 1'b1;
    op_class = CLS_ALU;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    aluop    = '0;
    signop   = '0;
    if (op_match(opcode, OP_LDUR_VAL, MASK_EXACT)) begin
      op_class = CLS_LOAD;
      alusrc   = 1'b1;
      mem2reg  = 1'b1;
      aluop    = ALUOP_ADD;
      signop   = SIGNOP_DT;
    end else if (op_match(opcode, OP_STUR_VAL, MASK_EXACT)) begin
      op_class = CLS_STORE;
      reg2loc  = 1'b1;
      alusrc   = 1'b1;
      aluop    = ALUOP_ADD;
      signop   = SIGNOP_DT;
    end else if (op_match(opcode, OP_ADDREG_VAL, MASK_EXACT)) begin
      aluop = ALUOP_ADD;
    end else if (op_match(opcode, OP_SUBREG_VAL, MASK_EXACT)) begin
      aluop = ALUOP_SUB;
    end else if (op_match(opcode, OP_ANDREG_VAL, MASK_EXACT)) begin
      aluop = ALUOP_AND;
    end else if (op_match(opcode, OP_ORRREG_VAL, MASK_EXACT)) begin
      aluop = ALUOP_ORR;
    end else if (op_match(opcode, OP_ADDIMM_VAL, OP_ADDIMM_MASK)) begin
      alusrc = 1'b1;
      aluop  = ALUOP_ADD;
      signop = SIGNOP_ARITH;
    end else if (op_match(opcode, OP_SUBIMM_VAL, OP_SUBIMM_MASK)) begin
      alusrc = 1'b1;
      aluop  = ALUOP_SUB;
      signop = SIGNOP_ARITH;
    end else if (op_match(opcode, OP_CBZ_VAL, OP_CBZ_MASK)) begin
      op_class = CLS_CBZ;
      reg2loc  = 1'b1;
      aluop    = ALUOP_PASSB;
      signop   = SIGNOP_CB;
    end else if (op_match(opcode, OP_B_VAL, OP_B_MASK)) begin
      op_class = CLS_B;
      signop   = SIGNOP_BR;
    end else if (op_match(opcode, OP_MOVZ_VAL, OP_MOVZ_MASK)) begin
      alusrc = 1'b1;
      aluop  = ALUOP_PASSB;
      signop = SIGNOP_MOV;
    end else begin
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle LEGv8 control FSM with memory-ready stalls, stall timeout and a
// saturating retired-instruction counter.
module multi_cycle_control
  import multi_cycle_pkg::*;
#(
  parameter int OPCODE_W  = 11,
  parameter int ALUOP_W   = 4,
  parameter int SIGNOP_W  = 3,
  parameter int RETIRE_W  = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                zero,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg2loc,
  output logic                alusrc,
  output logic                mem2reg,
  output logic                regwrite,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [SIGNOP_W-1:0] signop,
  output logic [2:0]          state,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  state_e                state_q, state_d;
  logic                  run_q;
  logic [TIMEOUT_W-1:0]  wait_q, wait_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  illegal_q, illegal_d;
  logic                  bus_err_q, bus_err_d;
  op_class_e             class_q, class_d;
  logic                  reg2loc_q, reg2loc_d;
  logic                  alusrc_q, alusrc_d;
  logic                  mem2reg_q, mem2reg_d;
  logic [ALUOP_W-1:0]    aluop_q, aluop_d;
  logic [SIGNOP_W-1:0]   signop_q, signop_d;
  logic                  retire_inc;

  logic                  dec_legal;
  op_class_e             dec_class;
  logic                  dec_reg2loc, dec_alusrc, dec_mem2reg;
  logic [ALUOP_W-1:0]    dec_aluop;
  logic [SIGNOP_W-1:0]   dec_signop;

  legv8_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W),
    .SIGNOP_W (SIGNOP_W)
  ) u_decode (
    .opcode   (opcode),
    .legal    (dec_legal),
    .op_class (dec_class),
    .reg2loc  (dec_reg2loc),
    .alusrc   (dec_alusrc),
    .mem2reg  (dec_mem2reg),
    .aluop    (dec_aluop),
    .signop   (dec_signop)
  );

  // run_q keeps every output quiet until the first edge after reset releases.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      run_q     <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      class_q   <= CLS_ALU;
      reg2loc_q <= 1'b0;
      alusrc_q  <= 1'b0;
      mem2reg_q <= 1'b0;
      aluop_q   <= '0;
      signop_q  <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      class_q   <= class_d;
      reg2loc_q <= reg2loc_d;
      alusrc_q  <= alusrc_d;
      mem2reg_q <= mem2reg_d;
      aluop_q   <= aluop_d;
      signop_q  <= signop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    class_d    = class_q;
    reg2loc_d  = reg2loc_q;
    alusrc_d   = alusrc_q;
    mem2reg_d  = mem2reg_q;
    aluop_d    = aluop_q;
    signop_d   = signop_q;
    retire_inc = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    regwrite   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            state_d  = ST_DECODE;
          end else begin
            wait_d = wait_q + TIMEOUT_W'(1);
            if (wait_q == WAIT_LAST) begin
              bus_err_d = 1'b1;
              state_d   = ST_HALT;
            end
          end
        end
        ST_DECODE: begin
          class_d   = dec_class;
          reg2loc_d = dec_reg2loc;
          alusrc_d  = dec_alusrc;
          mem2reg_d = dec_mem2reg;
          aluop_d   = dec_aluop;
          signop_d  = dec_signop;
          if (dec_legal) begin
            state_d = ST_EXEC;
          end else begin
            illegal_d = 1'b1;
            pc_write  = 1'b1;
            wait_d    = '0;
            state_d   = ST_FETCH;
          end
        end
        ST_EXEC: begin
          case (class_q)
            CLS_B, CLS_CBZ: begin
              pc_write   = 1'b1;
              pc_src     = (class_q == CLS_B) ? 1'b1 : zero;
              retire_inc = 1'b1;
              wait_d     = '0;
              state_d    = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: begin
              wait_d  = '0;
              state_d = ST_MEM;
            end
            default: state_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (class_q == CLS_STORE);
          if (dmem_ready) begin
            if (class_q == CLS_STORE) begin
              pc_write   = 1'b1;
              retire_inc = 1'b1;
              wait_d     = '0;
              state_d    = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else begin
            wait_d = wait_q + TIMEOUT_W'(1);
            if (wait_q == WAIT_LAST) begin
              bus_err_d = 1'b1;
              state_d   = ST_HALT;
            end
          end
        end
        ST_WB: begin
          regwrite   = 1'b1;
          pc_write   = 1'b1;
          retire_inc = 1'b1;
          wait_d     = '0;
          state_d    = ST_FETCH;
        end
        ST_HALT: state_d = ST_HALT;
        default: begin
          wait_d  = '0;
          state_d = ST_FETCH;
        end
      endcase
    end
    retired_d = (retire_inc && (retired_q != {RETIRE_W{1'b1}}))
                ? retired_q + RETIRE_W'(1) : retired_q;
  end

  assign reg2loc    = reg2loc_q;
  assign alusrc     = alusrc_q;
  assign mem2reg    = mem2reg_q;
  assign aluop      = aluop_q;
  assign signop     = signop_q;
  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign bus_error  = bus_err_q;
  assign retired    = retired_q;

endmodule
